// File: rtl/div_datapath_controller.sv
// rtl/div_datapath_controller.sv - unsigned repeated-subtraction divider with load/subtract FSM
//
// Purpose: divides dividend A by divisor B by subtracting B from the remainder
//          until it drops below B, counting the subtractions in Q. Operands
//          arrive one after another on a shared bus: dividend first, then divisor.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   data_in    shared operand bus (dividend, then divisor)
//   start      level request, sampled in IDLE and DONE
//   quotient   Q register; qualify with done
//   remainder  R register; qualify with done
//   done       high while the FSM is in DONE
//   div_zero   high in DONE when the divisor was zero (DIV_ZERO_DETECT_EN only)
// Configuration macro: DIV_ZERO_DETECT_EN enables early divide-by-zero exit and div_zero.

module div_datapath_controller #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             start,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
`ifdef DIV_ZERO_DETECT_EN
    ,
    output logic             div_zero
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_SUB    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
`ifdef DIV_ZERO_DETECT_EN
    logic             div_zero_q, div_zero_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            q_q     <= '0;
`ifdef DIV_ZERO_DETECT_EN
            div_zero_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            q_q     <= q_d;
`ifdef DIV_ZERO_DETECT_EN
            div_zero_q <= div_zero_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        q_d     = q_q;
`ifdef DIV_ZERO_DETECT_EN
        div_zero_d = div_zero_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD_A;
                end
            end
            ST_LOAD_A: begin
                a_d     = data_in;
                state_d = ST_LOAD_B;
            end
            ST_LOAD_B: begin
                b_d     = data_in;
                r_d     = a_q;
                q_d     = '0;
                state_d = ST_SUB;
            end
            ST_SUB: begin
`ifdef DIV_ZERO_DETECT_EN
                if (b_q == '0) begin
                    // Report the same saturated result the slow path would reach.
                    q_d        = '1;
                    r_d        = a_q;
                    div_zero_d = 1'b1;
                    state_d    = ST_DONE;
                end else
`endif
                // The Q!=all-ones guard bounds the loop (B==0 or quotient overflow).
                if ((r_q >= b_q) && (q_q != '1)) begin
                    r_d = r_q - b_q;
                    q_d = q_q + WIDTH'(1);
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // No auto-restart: start must fall before a new operation.
                if (!start) begin
                    state_d = ST_IDLE;
`ifdef DIV_ZERO_DETECT_EN
                    div_zero_d = 1'b0;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign quotient  = q_q;
    assign remainder = r_q;
    assign done      = (state_q == ST_DONE);
`ifdef DIV_ZERO_DETECT_EN
    assign div_zero  = div_zero_q;
`endif

endmodule

// File: tb/tb_div_datapath_controller.sv
// tb/tb_div_datapath_controller.sv - directed scoreboard bench for div_datapath_controller

module tb_div_datapath_controller;

    localparam int WIDTH = 16;
    localparam int MAX_CYCLES = 70000;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] data_in;
    logic             start;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             done;
`ifdef DIV_ZERO_DETECT_EN
    logic             div_zero;
`endif

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        int               cycles;
        logic             dz;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    div_datapath_controller #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .start     (start),
        .quotient  (quotient),
        .remainder (remainder),
        .done      (done)
`ifdef DIV_ZERO_DETECT_EN
        ,
        .div_zero  (div_zero)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference model: quotient/remainder with saturation and SUB-cycle count.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        e.dz = 1'b0;
        if (b == 0) begin
            e.q = {WIDTH{1'b1}};
            e.r = a;
`ifdef DIV_ZERO_DETECT_EN
            e.cycles = 1;
            e.dz     = 1'b1;
`else
            e.cycles = 1 << WIDTH;
`endif
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.cycles = int'(a / b) + 1;
        end
        return e;
    endfunction

    // Drops start so the FSM returns to IDLE, then loads a and b and waits for done.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        int   n;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        sb.push_back(model(a, b));
        data_in = a;
        start   = 1'b1;
        @(posedge clk);   // IDLE -> LOAD_A
        @(posedge clk);   // dividend sampled
        @(negedge clk);
        data_in = b;
        @(posedge clk);   // divisor sampled, enter SUB
        n = 0;
        while (n < MAX_CYCLES) begin
            @(posedge clk);
            n++;
            #1;
            if (done) break;
        end
        e = sb.pop_front();
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_q"}, 32'(quotient), 32'(e.q));
        check({tag, "_r"}, 32'(remainder), 32'(e.r));
        check({tag, "_sub_cycles"}, n, e.cycles);
`ifdef DIV_ZERO_DETECT_EN
        check({tag, "_div_zero"}, 32'(div_zero), 32'(e.dz));
`endif
    endtask

    initial begin
        exp_t e;
        rst     = 1'b1;
        start   = 1'b0;
        data_in = '0;

        #1;
        check("reset_q", 32'(quotient), 32'd0);
        check("reset_r", 32'(remainder), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        #1 rst = 1'b0;

        // Timed example: 17 / 5, done rises on the 65ns edge.
        #1;
        sb.push_back(model(16'd17, 16'd5));
        start   = 1'b1;
        data_in = 16'd17;
        #20 data_in = 16'd5;
        #41;
        check("t17_done_before_65", 32'(done), 32'd0);
        #2;
        e = sb.pop_front();
        check("t17_done_at_65", 32'(done), 32'd1);
        check("t17_q", 32'(quotient), 32'(e.q));
        check("t17_r", 32'(remainder), 32'(e.r));
        repeat (5) @(posedge clk);
        #1;
        check("t17_done_held", 32'(done), 32'd1);
        check("t17_q_held", 32'(quotient), 32'd3);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("t17_done_cleared", 32'(done), 32'd0);

        run_op("eq_100", 16'd100, 16'd100);
        run_op("lt_7_9", 16'd7, 16'd9);
        run_op("zero_a", 16'd0, 16'd3);
        run_op("div_by_0", 16'd1234, 16'd0);

        // Reset in the middle of a long SUB loop.
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        data_in = 16'd50000;
        start   = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        data_in = 16'd1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst_q", 32'(quotient), 32'd0);
        check("midrst_r", 32'(remainder), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        #1 rst = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_idle_done", 32'(done), 32'd0);

        run_op("after_rst_9_4", 16'd9, 16'd4);
        run_op("max_max", 16'd65535, 16'd65535);
        run_op("rand_a", 16'($urandom_range(0, 4000)), 16'($urandom_range(1, 300)));

        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
